// File: rtl/prga_multi.sv
// prga_multi: ARC4 pseudo-random generation / decrypt engine.
// Runs after the KSA has filled S. While busy it owns the S, CT and PT ports.
// It copies the little-endian length prefix (LB = ADDR_W/8 bytes) from CT to PT
// and discards DROP_N keystream bytes. For each message byte it then writes
// pt = ct ^ ks, or pt = ks when ks_mode was set at start.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   en, rdy, ks_mode    start handshake (en honoured while rdy=1), mode latched at start
//   s_addr/s_rddata/s_wrdata/s_wren      S memory (sync read, 1-cycle latency)
//   ct_addr/ct_rddata                    ciphertext memory (read-only, 1-cycle latency)
//   pt_addr/pt_wrdata/pt_wren            plaintext memory
//   bad                 only with PRGA_PRINTABLE_CHECK_EN: non-printable byte seen
//
// Optional feature macro: PRGA_PRINTABLE_CHECK_EN
//
// state  | meaning
// IDLE   | waiting for en
// LEN_RD | present length prefix byte k on ct_addr
// LEN_WR | capture prefix byte k into len, copy it to pt
// RD_I   | read S[i]
// RD_J   | latch si, j += si, read S[j]
// WR_I   | latch sj, S[i] = sj
// WR_J   | S[j] = si (end of a drop iteration, or go on to RD_K)
// RD_K   | read S[si+sj] and ct[k]
// XOR    | write pt[k], advance i and k
// DONE   | one idle cycle before rdy returns
module prga_multi #(
  parameter int ADDR_W = 8,
  parameter int DROP_N = 0,
  parameter int DROP_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              rdy,
  input  logic              ks_mode,
  output logic [7:0]        s_addr,
  input  logic [7:0]        s_rddata,
  output logic [7:0]        s_wrdata,
  output logic              s_wren,
  output logic [ADDR_W-1:0] ct_addr,
  input  logic [7:0]        ct_rddata,
  output logic [ADDR_W-1:0] pt_addr,
  output logic [7:0]        pt_wrdata,
`ifdef PRGA_PRINTABLE_CHECK_EN
  output logic              pt_wren,
  output logic              bad
`else
  output logic              pt_wren
`endif
);

  localparam int LB = ADDR_W / 8;
  localparam logic [ADDR_W-1:0] LB_W      = ADDR_W'(LB);
  localparam logic [ADDR_W-1:0] LEN_MAX   = ADDR_W'((1 << ADDR_W) - LB);
  localparam logic [DROP_W-1:0] DROP_LAST = DROP_W'(DROP_N - 1);

  typedef enum logic [3:0] {
    IDLE, LEN_RD, LEN_WR, RD_I, RD_J, WR_I, WR_J, RD_K, XOR, DONE
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
  logic [ADDR_W-1:0]   k_q, k_d, len_q, len_d;
  logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic                dropping_q, dropping_d;
  logic                ks_mode_q, ks_mode_d;
  logic [7:0]          pt_byte;
  logic [ADDR_W-1:0]   len_nxt;
  logic [ADDR_W-1:0]   data_cnt;
`ifdef PRGA_PRINTABLE_CHECK_EN
  logic                bad_q, bad_d;
  assign bad = bad_q;
`endif

  assign pt_byte  = ks_mode_q ? s_rddata : (s_rddata ^ ct_rddata);
  // Number of data bytes written once the current XOR completes.
  assign data_cnt = k_q - LB_W + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      i_q        <= 8'd1;
      j_q        <= 8'd0;
      si_q       <= 8'd0;
      sj_q       <= 8'd0;
      k_q        <= '0;
      len_q      <= '0;
      drop_cnt_q <= '0;
      dropping_q <= 1'b0;
      ks_mode_q  <= 1'b0;
`ifdef PRGA_PRINTABLE_CHECK_EN
      bad_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      si_q       <= si_d;
      sj_q       <= sj_d;
      k_q        <= k_d;
      len_q      <= len_d;
      drop_cnt_q <= drop_cnt_d;
      dropping_q <= dropping_d;
      ks_mode_q  <= ks_mode_d;
`ifdef PRGA_PRINTABLE_CHECK_EN
      bad_q      <= bad_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    si_d       = si_q;
    sj_d       = sj_q;
    k_d        = k_q;
    len_d      = len_q;
    drop_cnt_d = drop_cnt_q;
    dropping_d = dropping_q;
    ks_mode_d  = ks_mode_q;
    len_nxt    = len_q;
`ifdef PRGA_PRINTABLE_CHECK_EN
    bad_d      = bad_q;
`endif
    case (state_q)
      IDLE: if (en) begin
        state_d    = LEN_RD;
        i_d        = 8'd1;
        j_d        = 8'd0;
        k_d        = '0;
        len_d      = '0;
        drop_cnt_d = '0;
        dropping_d = 1'b0;
        ks_mode_d  = ks_mode;
`ifdef PRGA_PRINTABLE_CHECK_EN
        bad_d      = 1'b0;
`endif
      end
      LEN_RD: state_d = LEN_WR;
      LEN_WR: begin
        for (int b = 0; b < LB; b++)
          if (k_q == ADDR_W'(b)) len_nxt[8*b +: 8] = ct_rddata;
        // Clamp so the last data byte still has an address: len + LB <= 2^ADDR_W.
        if (({1'b0, len_nxt} + (ADDR_W+1)'(LB)) > {1'b1, {ADDR_W{1'b0}}})
          len_nxt = LEN_MAX;
        len_d = len_nxt;
        k_d   = k_q + 1'b1;
        if (k_q == LB_W - 1'b1) begin
          if (DROP_N > 0) begin
            dropping_d = 1'b1;
            state_d    = RD_I;
          end else begin
            state_d = (len_nxt == '0) ? DONE : RD_I;
          end
        end else begin
          state_d = LEN_RD;
        end
      end
      RD_I: state_d = RD_J;
      RD_J: begin
        si_d    = s_rddata;
        j_d     = j_q + s_rddata;
        state_d = WR_I;
      end
      WR_I: begin
        sj_d    = s_rddata;
        state_d = WR_J;
      end
      WR_J: begin
        if (dropping_q) begin
          i_d        = i_q + 8'd1;
          drop_cnt_d = drop_cnt_q + 1'b1;
          if (drop_cnt_q == DROP_LAST) begin
            dropping_d = 1'b0;
            state_d    = (len_q == '0) ? DONE : RD_I;
          end else begin
            state_d = RD_I;
          end
        end else begin
          state_d = RD_K;
        end
      end
      RD_K: state_d = XOR;
      XOR: begin
        i_d     = i_q + 8'd1;
        k_d     = k_q + 1'b1;
        state_d = (data_cnt < len_q) ? RD_I : DONE;
`ifdef PRGA_PRINTABLE_CHECK_EN
        // Early key rejection: stop at the first non-printable plaintext byte.
        if (!ks_mode_q && (pt_byte < 8'h20 || pt_byte > 8'h7E)) begin
          bad_d   = 1'b1;
          state_d = DONE;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdy       = (state_q == IDLE);
    s_addr    = 8'd0;
    s_wrdata  = 8'd0;
    s_wren    = 1'b0;
    ct_addr   = '0;
    pt_addr   = '0;
    pt_wrdata = 8'd0;
    pt_wren   = 1'b0;
    case (state_q)
      LEN_RD: ct_addr = k_q;
      LEN_WR: begin
        pt_addr   = k_q;
        pt_wrdata = ct_rddata;
        pt_wren   = 1'b1;
      end
      RD_I: s_addr = i_q;
      RD_J: s_addr = j_q + s_rddata;
      WR_I: begin
        s_addr   = i_q;
        s_wrdata = s_rddata;
        s_wren   = 1'b1;
      end
      WR_J: begin
        s_addr   = j_q;
        s_wrdata = si_q;
        s_wren   = 1'b1;
      end
      RD_K: begin
        s_addr  = si_q + sj_q;
        ct_addr = k_q;
      end
      XOR: begin
        pt_addr   = k_q;
        pt_wrdata = pt_byte;
        pt_wren   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_prga_multi.sv
module tb_prga_multi;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int ntest = 0;
  int nfail = 0;

`ifdef PRGA_PRINTABLE_CHECK_EN
  localparam logic DEC_KS = 1'b1;  // zero-data runs use ks_mode so the check does not abort them
`else
  localparam logic DEC_KS = 1'b0;
`endif

  logic [2:0] en = '0;
  logic [2:0] ks = '0;
  logic       mem_clr = 1'b0;

  logic [7:0]  a_s_addr, a_s_wrdata, a_pt_wrdata, a_ct_addr, a_pt_addr, a_s_rd, a_ct_rd;
  logic        a_rdy, a_s_wren, a_pt_wren;
  logic [7:0]  b_s_addr, b_s_wrdata, b_pt_wrdata, b_ct_addr, b_pt_addr, b_s_rd, b_ct_rd;
  logic        b_rdy, b_s_wren, b_pt_wren;
  logic [7:0]  c_s_addr, c_s_wrdata, c_pt_wrdata, c_s_rd, c_ct_rd;
  logic [15:0] c_ct_addr, c_pt_addr;
  logic        c_rdy, c_s_wren, c_pt_wren;
`ifdef PRGA_PRINTABLE_CHECK_EN
  logic        a_bad, b_bad, c_bad;
`endif

  logic [2:0] rdy_v;
  assign rdy_v = {c_rdy, b_rdy, a_rdy};

  prga_multi #(.ADDR_W(8), .DROP_N(0), .DROP_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en[0]), .rdy(a_rdy), .ks_mode(ks[0]),
    .s_addr(a_s_addr), .s_rddata(a_s_rd), .s_wrdata(a_s_wrdata), .s_wren(a_s_wren),
    .ct_addr(a_ct_addr), .ct_rddata(a_ct_rd),
    .pt_addr(a_pt_addr), .pt_wrdata(a_pt_wrdata),
`ifdef PRGA_PRINTABLE_CHECK_EN
    .bad(a_bad),
`endif
    .pt_wren(a_pt_wren));

  prga_multi #(.ADDR_W(8), .DROP_N(1), .DROP_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en[1]), .rdy(b_rdy), .ks_mode(ks[1]),
    .s_addr(b_s_addr), .s_rddata(b_s_rd), .s_wrdata(b_s_wrdata), .s_wren(b_s_wren),
    .ct_addr(b_ct_addr), .ct_rddata(b_ct_rd),
    .pt_addr(b_pt_addr), .pt_wrdata(b_pt_wrdata),
`ifdef PRGA_PRINTABLE_CHECK_EN
    .bad(b_bad),
`endif
    .pt_wren(b_pt_wren));

  prga_multi #(.ADDR_W(16), .DROP_N(0), .DROP_W(16)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en[2]), .rdy(c_rdy), .ks_mode(ks[2]),
    .s_addr(c_s_addr), .s_rddata(c_s_rd), .s_wrdata(c_s_wrdata), .s_wren(c_s_wren),
    .ct_addr(c_ct_addr), .ct_rddata(c_ct_rd),
    .pt_addr(c_pt_addr), .pt_wrdata(c_pt_wrdata),
`ifdef PRGA_PRINTABLE_CHECK_EN
    .bad(c_bad),
`endif
    .pt_wren(c_pt_wren));

  // Memory models; only addresses below 256 are used by any test.
  logic [7:0] s_mem  [3][256];
  logic [7:0] ct_mem [3][256];
  logic [7:0] pt_mem [3][256];
  int         pt_wc  [3][256];
  int         s_wc   [3];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int x = 0; x < 3; x++) begin
        s_wc[x] <= 0;
        for (int n = 0; n < 256; n++) begin
          s_mem[x][n]  <= 8'(n);
          pt_mem[x][n] <= 8'hEE;
          pt_wc[x][n]  <= 0;
        end
      end
    end else begin
      if (a_s_wren) begin s_mem[0][a_s_addr] <= a_s_wrdata; s_wc[0] <= s_wc[0] + 1; end
      if (b_s_wren) begin s_mem[1][b_s_addr] <= b_s_wrdata; s_wc[1] <= s_wc[1] + 1; end
      if (c_s_wren) begin s_mem[2][c_s_addr] <= c_s_wrdata; s_wc[2] <= s_wc[2] + 1; end
      if (a_pt_wren) begin
        pt_mem[0][a_pt_addr] <= a_pt_wrdata; pt_wc[0][a_pt_addr] <= pt_wc[0][a_pt_addr] + 1;
      end
      if (b_pt_wren) begin
        pt_mem[1][b_pt_addr] <= b_pt_wrdata; pt_wc[1][b_pt_addr] <= pt_wc[1][b_pt_addr] + 1;
      end
      if (c_pt_wren) begin
        pt_mem[2][c_pt_addr[7:0]] <= c_pt_wrdata;
        pt_wc[2][c_pt_addr[7:0]]  <= pt_wc[2][c_pt_addr[7:0]] + 1;
      end
    end
    a_s_rd  <= s_mem[0][a_s_addr];
    b_s_rd  <= s_mem[1][b_s_addr];
    c_s_rd  <= s_mem[2][c_s_addr];
    a_ct_rd <= ct_mem[0][a_ct_addr];
    b_ct_rd <= ct_mem[1][b_ct_addr];
    c_ct_rd <= ct_mem[2][c_ct_addr[7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntest++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    @(negedge clk); mem_clr = 1'b1;
    @(negedge clk); mem_clr = 1'b0;
  endtask

  task automatic fill_ct(input int id, input logic [7:0] v);
    for (int n = 0; n < 256; n++) ct_mem[id][n] = v;
  endtask

  // Start engine id and count the cycles rdy stays low (bounded).
  task automatic run(input int id, input logic ksm, output int busy);
    @(negedge clk); en[id] = 1'b1; ks[id] = ksm;
    @(negedge clk); en[id] = 1'b0;
    busy = 0;
    while (rdy_v[id] == 1'b0 && busy < 1000) begin
      busy++;
      @(negedge clk);
    end
  endtask

  int busy;
  int found;

  initial begin
    for (int x = 0; x < 3; x++) fill_ct(x, 8'h00);
    repeat (3) @(negedge clk);
    chk("rst_rdy",      {31'd0, a_rdy}, 32'd1);
    chk("rst_s_wren",   {31'd0, a_s_wren}, 32'd0);
    chk("rst_pt_wren",  {31'd0, a_pt_wren}, 32'd0);
    chk("rst_s_addr",   {24'd0, a_s_addr}, 32'd0);
    chk("rst_ct_addr",  {24'd0, a_ct_addr}, 32'd0);
    chk("rst_pt_addr",  {24'd0, a_pt_addr}, 32'd0);
    chk("rst_pt_wdata", {24'd0, a_pt_wrdata}, 32'd0);
    rst_n = 1'b1;

    // Identity S, ct={03,00,00,00}, no drop.
    clr();
    fill_ct(0, 8'h00); ct_mem[0][0] = 8'h03;
    run(0, DEC_KS, busy);
    chk("t1_busy", busy, 21);
    chk("t1_pt0", {24'd0, pt_mem[0][0]}, 32'h03);
    chk("t1_pt1", {24'd0, pt_mem[0][1]}, 32'h02);
    chk("t1_pt2", {24'd0, pt_mem[0][2]}, 32'h05);
    chk("t1_pt3", {24'd0, pt_mem[0][3]}, 32'h07);
    chk("t1_s2",  {24'd0, s_mem[0][2]}, 32'h03);
    chk("t1_s3",  {24'd0, s_mem[0][3]}, 32'h05);
    chk("t1_s5",  {24'd0, s_mem[0][5]}, 32'h02);
    chk("t1_pt4_untouched", pt_wc[0][4], 0);

    // Same input with one dropped keystream byte.
    clr();
    fill_ct(1, 8'h00); ct_mem[1][0] = 8'h03;
    run(1, DEC_KS, busy);
    chk("t2_busy", busy, 25);
    chk("t2_pt0", {24'd0, pt_mem[1][0]}, 32'h03);
    chk("t2_pt1", {24'd0, pt_mem[1][1]}, 32'h05);
    chk("t2_pt2", {24'd0, pt_mem[1][2]}, 32'h07);
    chk("t2_pt3", {24'd0, pt_mem[1][3]}, 32'h0D);

    // Zero length: prefix copied, nothing else touched.
    clr();
    fill_ct(0, 8'h55); ct_mem[0][0] = 8'h00;
    run(0, 1'b0, busy);
    chk("t3_busy", busy, 3);
    chk("t3_pt0", {24'd0, pt_mem[0][0]}, 32'h00);
    chk("t3_pt0_wc", pt_wc[0][0], 1);
    chk("t3_pt1_wc", pt_wc[0][1], 0);
    chk("t3_s_wc", s_wc[0], 0);

    // 16-bit addressing, 2-byte prefix, keystream-only.
    clr();
    fill_ct(2, 8'h00);
    ct_mem[2][0] = 8'h03; ct_mem[2][1] = 8'h00;
    ct_mem[2][2] = 8'h41; ct_mem[2][3] = 8'h42; ct_mem[2][4] = 8'h43;
    run(2, 1'b1, busy);
    chk("t4_busy", busy, 23);
    chk("t4_pt0", {24'd0, pt_mem[2][0]}, 32'h03);
    chk("t4_pt1", {24'd0, pt_mem[2][1]}, 32'h00);
    chk("t4_pt2", {24'd0, pt_mem[2][2]}, 32'h02);
    chk("t4_pt3", {24'd0, pt_mem[2][3]}, 32'h05);
    chk("t4_pt4", {24'd0, pt_mem[2][4]}, 32'h07);

    // Reset during the second XOR of a len=3 run.
    clr();
    fill_ct(0, 8'h00); ct_mem[0][0] = 8'h03;
    @(negedge clk); en[0] = 1'b1; ks[0] = DEC_KS;
    @(negedge clk); en[0] = 1'b0;
    found = 0;
    for (int w = 0; w < 100; w++) begin
      if (a_pt_wren && a_pt_addr == 8'd2) begin found = 1; break; end
      @(negedge clk);
    end
    chk("mr_found", found, 1);
    rst_n = 1'b0;
    #1;
    chk("mr_rdy",     {31'd0, a_rdy}, 32'd1);
    chk("mr_s_wren",  {31'd0, a_s_wren}, 32'd0);
    chk("mr_pt_wren", {31'd0, a_pt_wren}, 32'd0);
    @(negedge clk);
    chk("mr_pt2_wc", pt_wc[0][2], 0);
    rst_n = 1'b1;
    clr();
    fill_ct(0, 8'h00); ct_mem[0][0] = 8'h01;
    run(0, DEC_KS, busy);
    chk("mr_restart_busy", busy, 9);
    chk("mr_restart_pt1", {24'd0, pt_mem[0][1]}, 32'h02);

`ifdef PRGA_PRINTABLE_CHECK_EN
    clr();
    fill_ct(0, 8'h00);
    ct_mem[0][0] = 8'h03; ct_mem[0][1] = 8'h43; ct_mem[0][2] = 8'h05; ct_mem[0][3] = 8'h07;
    run(0, 1'b0, busy);
    chk("pc_busy", busy, 15);
    chk("pc_bad", {31'd0, a_bad}, 32'd1);
    chk("pc_pt1", {24'd0, pt_mem[0][1]}, 32'h41);
    chk("pc_pt2", {24'd0, pt_mem[0][2]}, 32'h00);
    chk("pc_pt3_wc", pt_wc[0][3], 0);
    clr();
    run(0, 1'b1, busy);
    chk("pc_bad_cleared", {31'd0, a_bad}, 32'd0);
    chk("pc_ks_pt3_wc", pt_wc[0][3], 1);
`endif

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
